// File: rtl/acf_stream_reader_if.sv
// Stream-side signal bundle of acf_stream_reader: correlator word input, frame control/status
// and the 32-bit AXI4-Stream output. master = the reader itself, slave = the environment.
interface acf_stream_reader_if #(
  parameter int W = 53
);
  logic          start;
  logic          initTx;
  logic [W-1:0]  acfEl;
  logic          wrEn;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy;
  logic          overflow;
  logic          timeout;
  logic [15:0]   frameCount;

  modport master (
    input  start, acfEl, wrEn, m_axis_tready,
    output initTx, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
           busy, overflow, timeout, frameCount
  );

  modport slave (
    output start, acfEl, wrEn, m_axis_tready,
    input  initTx, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
           busy, overflow, timeout, frameCount
  );
endinterface

// File: rtl/acf_stream_reader.sv
// Requests one ACF frame from the correlator, buffers its words and streams each as two 32-bit beats.
// Optional build macro ACF_HDR_EN prepends a {16'hACF0, frameCount} header beat to every frame.
module acf_stream_reader #(
  parameter int BIN_SIZE    = 8,
  parameter int NUM_BINS    = 20,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                 CLK,
  input logic                 rst,
  acf_stream_reader_if.master stream_io
);

  localparam int W      = NUM_BINS + 33;
  localparam int HW     = W - 32;
  localparam int NWORDS = 1 + BIN_SIZE * (NUM_BINS + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(NWORDS + 1);
  localparam int TW     = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COLLECT,
    DRAIN
  } state_t;

  state_t          state_q;
  logic [W:0]      fifoMem_q [FIFO_DEPTH];
  logic [AW:0]     wrPtr_q;
  logic [AW:0]     rdPtr_q;
  logic [CW-1:0]   wordCnt_q;
  logic [TW-1:0]   idleCnt_q;
  logic [31:0]     tdata_q;
  logic            tvalid_q;
  logic            tlast_q;
  logic [HW-1:0]   hiWord_q;
  logic            hiLast_q;
  logic            hiPending_q;
  logic            initTx_q;
  logic            busy_q;
  logic            overflow_q;
  logic            timeout_q;
  logic [15:0]     frameCount_q;

  logic            fifoEmpty;
  logic            fifoFull;
  logic            outFree;
  logic            pop;
  logic            push;
  logic            lastWord;
  logic            abort;
  logic            drainDone;
  logic [W:0]      rdWord;

  // Each FIFO entry carries a tag bit marking the frame's final word, so tlast survives drops.
  always_comb begin
    fifoEmpty = (wrPtr_q == rdPtr_q);
    fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    rdWord    = fifoMem_q[rdPtr_q[AW-1:0]];
    outFree   = !tvalid_q || stream_io.m_axis_tready;
    pop       = outFree && !hiPending_q && !fifoEmpty;
    lastWord  = (wordCnt_q == CW'(NWORDS - 1));
    push      = (state_q == COLLECT) && stream_io.wrEn && (!fifoFull || pop);
    abort     = (state_q == COLLECT) && !stream_io.wrEn && (idleCnt_q == TW'(TIMEOUT_CYC - 1));
    drainDone = (state_q == DRAIN) && fifoEmpty && outFree && !hiPending_q;
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifoMem_q[wrPtr_q[AW-1:0]] <= {lastWord, stream_io.acfEl};
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= IDLE;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      wordCnt_q    <= '0;
      idleCnt_q    <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      hiWord_q     <= '0;
      hiLast_q     <= 1'b0;
      hiPending_q  <= 1'b0;
      initTx_q     <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      frameCount_q <= '0;
    end else begin
      initTx_q <= 1'b0;

      // Output register: the owed upper half goes first, otherwise the next FIFO word's lower half.
      if (outFree) begin
        if (hiPending_q) begin
          tdata_q     <= 32'(hiWord_q);
          tlast_q     <= hiLast_q;
          tvalid_q    <= 1'b1;
          hiPending_q <= 1'b0;
        end else if (!fifoEmpty) begin
          tdata_q     <= rdWord[31:0];
          hiWord_q    <= rdWord[W-1:32];
          hiLast_q    <= rdWord[W];
          tlast_q     <= 1'b0;
          tvalid_q    <= 1'b1;
          hiPending_q <= 1'b1;
        end else begin
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
        end
      end

      if (push) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (stream_io.start) begin
            state_q    <= ARM;
            busy_q     <= 1'b1;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            initTx_q   <= 1'b1;
          end
        end
        ARM: begin
          state_q   <= COLLECT;
          wordCnt_q <= '0;
          idleCnt_q <= '0;
`ifdef ACF_HDR_EN
          tdata_q     <= {16'hACF0, frameCount_q};
          tlast_q     <= 1'b0;
          tvalid_q    <= 1'b1;
          hiPending_q <= 1'b0;
`endif
        end
        COLLECT: begin
          if (stream_io.wrEn) begin
            idleCnt_q <= '0;
            if (!push) begin
              overflow_q <= 1'b1;
            end
            if (lastWord) begin
              state_q <= DRAIN;
            end else begin
              wordCnt_q <= wordCnt_q + CW'(1);
            end
          end else if (abort) begin
            // Abandon the frame: discard buffered words and any beat in flight without tlast.
            state_q     <= IDLE;
            timeout_q   <= 1'b1;
            busy_q      <= 1'b0;
            rdPtr_q     <= wrPtr_q;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            hiPending_q <= 1'b0;
          end else begin
            idleCnt_q <= idleCnt_q + TW'(1);
          end
        end
        DRAIN: begin
          if (drainDone) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frameCount_q <= frameCount_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stream_io.initTx        = initTx_q;
  assign stream_io.m_axis_tdata  = tdata_q;
  assign stream_io.m_axis_tvalid = tvalid_q;
  assign stream_io.m_axis_tlast  = tlast_q;
  assign stream_io.busy          = busy_q;
  assign stream_io.overflow      = overflow_q;
  assign stream_io.timeout       = timeout_q;
  assign stream_io.frameCount    = frameCount_q;

endmodule

// File: tb/tb_acf_stream_reader.sv
// Directed bench for acf_stream_reader: full frames, stalls, overflow, timeout, reset mid-frame, headers.
module tb_acf_stream_reader;

  localparam int W      = 53;
  localparam int NWORDS = 169;
`ifdef ACF_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic CLK = 1'b0;
  logic rst;
  always #5 CLK = ~CLK;

  acf_stream_reader_if #(.W(W)) acfBus ();

  acf_stream_reader #(
    .BIN_SIZE(8),
    .NUM_BINS(20),
    .FIFO_DEPTH(16),
    .TIMEOUT_CYC(1024)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .stream_io(acfBus)
  );

  int checks = 0;
  int errors = 0;
  int readyMode;

  // Beat monitor: records handshakes, initTx pulses and any change while stalled.
  logic [31:0] beatData [$];
  logic        beatLast [$];
  int          initCount = 0;
  int          stallErr  = 0;
  logic        stalledPrev = 1'b0;
  logic [31:0] prevData;
  logic        prevLast;

  always @(negedge CLK) begin
    if (acfBus.initTx) initCount++;
    if (stalledPrev && (acfBus.m_axis_tvalid !== 1'b1 || acfBus.m_axis_tdata !== prevData ||
                        acfBus.m_axis_tlast !== prevLast))
      stallErr++;
    if (!rst && acfBus.m_axis_tvalid && acfBus.m_axis_tready) begin
      beatData.push_back(acfBus.m_axis_tdata);
      beatLast.push_back(acfBus.m_axis_tlast);
    end
    stalledPrev = !rst && acfBus.m_axis_tvalid && !acfBus.m_axis_tready;
    prevData    = acfBus.m_axis_tdata;
    prevLast    = acfBus.m_axis_tlast;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    case (readyMode)
      0:       acfBus.m_axis_tready = 1'b0;
      1:       acfBus.m_axis_tready = 1'b1;
      default: acfBus.m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int first, input int count, input bit hiPat, input int gap);
    logic [W-1:0] w;
    for (int k = first; k < first + count; k++) begin
      w = W'(k);
      if (hiPat) w[W-1:32] = (W-32)'(k);
      acfBus.acfEl = w;
      acfBus.wrEn  = 1'b1;
      tick();
      acfBus.wrEn  = 1'b0;
      repeat (gap - 1) tick();
    end
  endtask

  task automatic startFrame(input string tag);
    acfBus.start = 1'b1;
    tick();
    acfBus.start = 1'b0;
    checkOutput({tag, "_busyAfterStart"}, acfBus.busy, 1);
    checkOutput({tag, "_initTxHigh"}, acfBus.initTx, 1);
    tick();
    checkOutput({tag, "_initTxLow"}, acfBus.initTx, 0);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (acfBus.busy && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_endsInBudget"}, acfBus.busy, 0);
  endtask

  task automatic checkFrame(input string tag, input int base, input int nWords, input bit hiPat,
                            input int fc, input int expLast);
    int lastCnt = 0;
    int i;
    checkOutput({tag, "_beatCount"}, beatData.size() - base, HDR + 2 * nWords);
`ifdef ACF_HDR_EN
    checkOutput({tag, "_header"}, beatData[base], {16'hACF0, 16'(fc)});
`endif
    for (int k = 0; k < nWords; k++) begin
      i = base + HDR + 2 * k;
      if (i + 1 < beatData.size()) begin
        checkOutput($sformatf("%s_w%0d_lo", tag, k), beatData[i], 32'(k));
        checkOutput($sformatf("%s_w%0d_hi", tag, k), beatData[i+1], hiPat ? 32'(k) : 32'd0);
      end
    end
    for (int j = base; j < beatData.size(); j++) if (beatLast[j]) lastCnt++;
    checkOutput({tag, "_tlastCount"}, lastCnt, expLast);
    if (expLast != 0 && beatData.size() > base)
      checkOutput({tag, "_tlastOnFinal"}, beatLast[beatData.size()-1], 1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_tvalid"}, acfBus.m_axis_tvalid, 0);
    checkOutput({tag, "_tlast"}, acfBus.m_axis_tlast, 0);
    checkOutput({tag, "_tdata"}, acfBus.m_axis_tdata, 0);
    checkOutput({tag, "_busy"}, acfBus.busy, 0);
    checkOutput({tag, "_overflow"}, acfBus.overflow, 0);
    checkOutput({tag, "_timeout"}, acfBus.timeout, 0);
    checkOutput({tag, "_frameCount"}, acfBus.frameCount, 0);
    checkOutput({tag, "_initTx"}, acfBus.initTx, 0);
  endtask

  initial begin
    int base;
    int i0;
    int k;

    rst = 1'b1;
    acfBus.start = 1'b0;
    acfBus.wrEn = 1'b0;
    acfBus.acfEl = '0;
    acfBus.m_axis_tready = 1'b1;
    readyMode = 1;
    repeat (3) tick();
    checkResetState("reset");
    rst = 1'b0;
    tick();

    $display("[TB] T1 full frame, tready=1");
    base = beatData.size();
    i0 = initCount;
    startFrame("t1");
    acfBus.acfEl = '0;
    acfBus.wrEn = 1'b1;
    tick();
    acfBus.wrEn = 1'b0;
    checkOutput("t1_latencyCycle1", acfBus.m_axis_tvalid, 0);
    tick();
    checkOutput("t1_latencyCycle2", acfBus.m_axis_tvalid, 1);
    applyStimulus(1, NWORDS - 1, 1'b0, 2);
    waitIdle("t1", 2000);
    checkFrame("t1", base, NWORDS, 1'b0, 0, 1);
    checkOutput("t1_initPulses", initCount - i0, 1);
    checkOutput("t1_frameCount", acfBus.frameCount, 1);
    checkOutput("t1_tvalidIdle", acfBus.m_axis_tvalid, 0);

    $display("[TB] T2 random tready, split upper half, start ignored mid-frame");
    readyMode = 2;
    base = beatData.size();
    i0 = initCount;
    startFrame("t2");
    applyStimulus(0, 60, 1'b1, 8);
    acfBus.start = 1'b1;
    tick();
    acfBus.start = 1'b0;
    tick();
    applyStimulus(60, NWORDS - 60, 1'b1, 8);
    waitIdle("t2", 4000);
    checkFrame("t2", base, NWORDS, 1'b1, 1, 1);
    checkOutput("t2_stableWhileStalled", stallErr, 0);
    checkOutput("t2_overflow", acfBus.overflow, 0);
    checkOutput("t2_initPulses", initCount - i0, 1);
    checkOutput("t2_frameCount", acfBus.frameCount, 2);

    $display("[TB] T3 tready held low, overflow");
    readyMode = 0;
    tick();
    base = beatData.size();
    startFrame("t3");
    applyStimulus(0, NWORDS, 1'b0, 2);
    checkOutput("t3_overflow", acfBus.overflow, 1);
    checkOutput("t3_busyStalled", acfBus.busy, 1);
    checkOutput("t3_tvalidHeld", acfBus.m_axis_tvalid, 1);
    readyMode = 1;
    tick();
    waitIdle("t3", 500);
    checkFrame("t3", base, 17 - HDR, 1'b0, 2, 0);
    checkOutput("t3_frameCount", acfBus.frameCount, 3);

    $display("[TB] T4 timeout after 100 words");
    base = beatData.size();
    startFrame("t4");
    checkOutput("t4_overflowCleared", acfBus.overflow, 0);
    applyStimulus(0, 100, 1'b0, 2);
    repeat (1020) tick();
    checkOutput("t4_noEarlyTimeout", acfBus.timeout, 0);
    checkOutput("t4_busyWaiting", acfBus.busy, 1);
    repeat (10) tick();
    checkOutput("t4_timeout", acfBus.timeout, 1);
    checkOutput("t4_busyDropped", acfBus.busy, 0);
    checkOutput("t4_tvalid", acfBus.m_axis_tvalid, 0);
    checkOutput("t4_frameCount", acfBus.frameCount, 3);
    checkFrame("t4", base, 100, 1'b0, 3, 0);
    base = beatData.size();
    applyStimulus(0, 5, 1'b0, 2);
    repeat (5) tick();
    checkOutput("t4_idleWordsIgnored", beatData.size() - base, 0);
    checkOutput("t4_idleFrameCount", acfBus.frameCount, 3);
    checkOutput("t4_timeoutSticky", acfBus.timeout, 1);

    $display("[TB] T5 reset mid-frame");
    base = beatData.size();
    startFrame("t5");
    k = 0;
    while (beatData.size() - base < 50 && k < NWORDS) begin
      applyStimulus(k, 1, 1'b0, 2);
      k++;
    end
    rst = 1'b1;
    tick();
    checkResetState("t5_reset");
    rst = 1'b0;
    tick();
    base = beatData.size();
    startFrame("t5b");
    applyStimulus(0, NWORDS, 1'b0, 2);
    waitIdle("t5b", 2000);
    checkFrame("t5b", base, NWORDS, 1'b0, 0, 1);
    checkOutput("t5b_frameCount", acfBus.frameCount, 1);

    $display("[TB] T6 second frame after reset");
    base = beatData.size();
    startFrame("t6");
    applyStimulus(0, NWORDS, 1'b1, 2);
    waitIdle("t6", 2000);
    checkFrame("t6", base, NWORDS, 1'b1, 1, 1);
    checkOutput("t6_frameCount", acfBus.frameCount, 2);
    checkOutput("t6_overflow", acfBus.overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
